// File: rtl/cpu_lsu_pkg.sv
// rtl/cpu_lsu_pkg.sv - shared types and helpers for the load/store unit
package cpu_lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  localparam logic [1:0] EXC_LOAD_MISALIGN  = 2'd1;
  localparam logic [1:0] EXC_STORE_MISALIGN = 2'd2;
  localparam logic [1:0] EXC_BUS_TIMEOUT    = 2'd3;

  function automatic logic op_is_store(input lsu_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic op_aligned(input lsu_op_t op, input logic [1:0] lo);
    case (op)
      LB, LBU, SB:  return 1'b1;
      LH, LHU, SH:  return ~lo[0];
      default:      return (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// rtl/cpu_lsu_align.sv - store lane replication/byte enables and load extract/extend
module cpu_lsu_align
  import cpu_lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_src,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_enable,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    byte_enable = 4'b0000;
    store_data  = 32'd0;
    load_data   = 32'd0;
    shifted     = rdata >> {addr_lo, 3'b000};
    case (op)
      SB: begin
        byte_enable = 4'b0001 << addr_lo;
        store_data  = {4{store_src[7:0]}};
      end
      SH: begin
        byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data  = {2{store_src[15:0]}};
      end
      SW: begin
        byte_enable = 4'b1111;
        store_data  = store_src;
      end
      LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     load_data = {24'd0, shifted[7:0]};
      LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/cpu_lsu.sv
// rtl/cpu_lsu.sv - load/store unit between execute stage and the data-cache port
module cpu_lsu
  import cpu_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_dest,
  output logic        cpud_request,
  output logic [31:0] cpud_addr,
  output logic        cpud_write,
  output logic [3:0]  cpud_byte_enable,
  output logic [31:0] cpud_wdata,
  input  logic [31:0] cpud_rdata,
  input  logic        cpud_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  state, state_nx;
  lsu_op_t     op_q;
  lsu_op_t     in_op_e;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  dest_q;
  logic [7:0]  wait_cnt;

  logic        accept;
  logic        in_aligned;
  logic        ack_wait;
  logic        timeout_hit;
  logic [3:0]  be;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign in_op_e     = lsu_op_t'(in_op);
  assign ack_wait    = (state == WAIT) && cpud_ack;
  assign in_ready    = (state == IDLE) || ack_wait;
  assign accept      = in_valid && in_ready;
  assign in_aligned  = op_aligned(in_op_e, in_addr[1:0]);
  // An ack in the last allowed cycle takes priority over the timeout.
  assign timeout_hit = (state == WAIT) && !cpud_ack && (wait_cnt == TIMEOUT_LAST);

  cpu_lsu_align u_align (
    .op          (op_q),
    .addr_lo     (addr_q[1:0]),
    .store_src   (wdata_q),
    .rdata       (cpud_rdata),
    .byte_enable (be),
    .store_data  (st_data),
    .load_data   (ld_data)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && in_aligned) state_nx = REQ;
      REQ:  state_nx = WAIT;
      WAIT: begin
        if (cpud_ack)         state_nx = (accept && in_aligned) ? REQ : IDLE;
        else if (timeout_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cpud_request     = (state == REQ);
  assign cpud_addr        = cpud_request ? addr_q : 32'd0;
  assign cpud_write       = cpud_request && op_is_store(op_q);
  assign cpud_byte_enable = cpud_request ? be : 4'b0000;
  assign cpud_wdata       = cpud_request ? st_data : 32'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_q      <= LW;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      dest_q    <= 5'd0;
      wait_cnt  <= 8'd0;
      wb_valid  <= 1'b0;
      wb_dest   <= 5'd0;
      wb_data   <= 32'd0;
      exc_valid <= 1'b0;
      exc_cause <= 2'd0;
      exc_addr  <= 32'd0;
    end else begin
      state     <= state_nx;
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;

      if (accept) begin
        op_q    <= in_op_e;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        dest_q  <= in_dest;
      end

      if ((state == WAIT) && !cpud_ack && !timeout_hit) wait_cnt <= wait_cnt + 8'd1;
      else                                              wait_cnt <= 8'd0;

      // Load data is extracted from the old op registers before they reload.
      if (ack_wait && !op_is_store(op_q)) begin
        wb_valid <= 1'b1;
        wb_dest  <= dest_q;
        wb_data  <= ld_data;
      end

      if (accept && !in_aligned) begin
        exc_valid <= 1'b1;
        exc_cause <= op_is_store(in_op_e) ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
        exc_addr  <= in_addr;
      end else if (timeout_hit) begin
        exc_valid <= 1'b1;
        exc_cause <= EXC_BUS_TIMEOUT;
        exc_addr  <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_cpu_lsu.sv
// tb/tb_cpu_lsu.sv - randomized self-checking bench for cpu_lsu
module tb_cpu_lsu;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_dest;
  logic        cpud_request;
  logic [31:0] cpud_addr;
  logic        cpud_write;
  logic [3:0]  cpud_byte_enable;
  logic [31:0] cpud_wdata;
  logic [31:0] cpud_rdata;
  logic        cpud_ack;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cpu_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_op            (in_op),
    .in_addr          (in_addr),
    .in_wdata         (in_wdata),
    .in_dest          (in_dest),
    .cpud_request     (cpud_request),
    .cpud_addr        (cpud_addr),
    .cpud_write       (cpud_write),
    .cpud_byte_enable (cpud_byte_enable),
    .cpud_wdata       (cpud_wdata),
    .cpud_rdata       (cpud_rdata),
    .cpud_ack         (cpud_ack),
    .wb_valid         (wb_valid),
    .wb_dest          (wb_dest),
    .wb_data          (wb_data),
    .exc_valid        (exc_valid),
    .exc_cause        (exc_cause),
    .exc_addr         (exc_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: ops 0..4 are LB,LBU,LH,LHU,LW; 5..7 are SB,SH,SW.
  function automatic int op_size(input int op);
    if (op == 0 || op == 1 || op == 5) return 1;
    if (op == 2 || op == 3 || op == 6) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_be(input int op, input logic [31:0] a);
    int sz = op_size(op);
    if (op < 5) return 32'd0;
    return 32'(((1 << sz) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] exp_wdata(input int op, input logic [31:0] wd);
    if (op < 5) return 32'd0;
    case (op_size(op))
      1:       return (wd & 32'hFF) * 32'h01010101;
      2:       return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input int op, input logic [31:0] a, input logic [31:0] rd);
    int    bits = 8 * op_size(op);
    longint v   = (longint'(rd) >> (8 * int'(a[1:0]))) & ((64'd1 << bits) - 1);
    if ((op == 0 || op == 2) && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return 32'(v);
  endfunction

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] dst, input int delay, input logic [31:0] rd);
    logic st = (op >= 5);
    @(negedge clock);
    check("idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = 3'(op); in_addr = a; in_wdata = wd; in_dest = dst;
    @(negedge clock);
    in_valid = 1'b0;
    if (int'(a[1:0]) % op_size(op) != 0) begin
      check("mis_exc", 32'(exc_valid), 32'd1);
      check("mis_cause", 32'(exc_cause), st ? 32'd2 : 32'd1);
      check("mis_addr", exc_addr, a);
      check("mis_noreq", 32'(cpud_request), 32'd0);
      return;
    end
    check("req", 32'(cpud_request), 32'd1);
    check("req_addr", cpud_addr, a);
    check("req_write", 32'(cpud_write), 32'(st));
    check("req_be", 32'(cpud_byte_enable), exp_be(op, a));
    check("req_wdata", cpud_wdata, exp_wdata(op, wd));
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clock);
      check("wait_quiet", 32'({cpud_request, wb_valid, exc_valid}), 32'd0);
      if (k == delay) begin
        cpud_ack = 1'b1; cpud_rdata = rd;
        #1;
        check("ack_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        cpud_ack = 1'b0; cpud_rdata = $urandom;
        check("wb_valid", 32'(wb_valid), 32'(!st));
        if (!st) begin
          check("wb_data", wb_data, exp_load(op, a, rd));
          check("wb_dest", 32'(wb_dest), 32'(dst));
        end
        check("done_exc", 32'(exc_valid), 32'd0);
        check("done_ready", 32'(in_ready), 32'd1);
        return;
      end
      check("wait_busy", 32'(in_ready), 32'd0);
    end
    @(negedge clock);
    check("to_exc", 32'(exc_valid), 32'd1);
    check("to_cause", 32'(exc_cause), 32'd3);
    check("to_addr", exc_addr, a);
    check("to_nowb", 32'(wb_valid), 32'd0);
    check("to_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_addr = 32'd0; in_wdata = 32'd0;
    in_dest = 5'd0; cpud_rdata = 32'd0; cpud_ack = 1'b0;
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_outs", 32'({cpud_request, cpud_write, cpud_byte_enable, wb_valid, exc_valid, exc_cause}), 32'd0);
    check("rst_addr", cpud_addr | cpud_wdata | wb_data | exc_addr, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op(7, 32'h100, 32'hDEADBEEF, 5'd1, 1, 32'd0);
    run_op(5, 32'h103, 32'h000000A5, 5'd2, 2, 32'd0);
    run_op(0, 32'h103, 32'd0, 5'd3, 1, 32'hA5000000);
    run_op(1, 32'h103, 32'd0, 5'd4, 3, 32'hA5000000);
    run_op(2, 32'h102, 32'd0, 5'd5, 1, 32'h80010000);
    run_op(4, 32'h102, 32'd0, 5'd6, 1, 32'd0);
    run_op(6, 32'h101, 32'h1234, 5'd6, 1, 32'd0);
    run_op(4, 32'h200, 32'd0, 5'd7, TIMEOUT, 32'h0BADF00D);
    run_op(4, 32'h400, 32'd0, 5'd8, 99, 32'd0);

    // spurious ack while idle after the timeout
    cpud_ack = 1'b1;
    @(negedge clock);
    cpud_ack = 1'b0;
    check("spur_nowb", 32'({wb_valid, exc_valid}), 32'd0);

    // back-to-back loads
    @(negedge clock);
    in_valid = 1'b1; in_op = 3'd4; in_addr = 32'h500; in_dest = 5'd3;
    @(negedge clock);
    in_valid = 1'b0;
    check("b2b_req1", 32'(cpud_request), 32'd1);
    @(negedge clock);
    cpud_ack = 1'b1; cpud_rdata = 32'h11223344;
    in_valid = 1'b1; in_op = 3'd4; in_addr = 32'h504; in_dest = 5'd9;
    #1;
    check("b2b_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    cpud_ack = 1'b0; in_valid = 1'b0;
    check("b2b_wb1", 32'(wb_valid), 32'd1);
    check("b2b_dest1", 32'(wb_dest), 32'd3);
    check("b2b_data1", wb_data, 32'h11223344);
    check("b2b_req2", 32'(cpud_request), 32'd1);
    check("b2b_addr2", cpud_addr, 32'h504);
    @(negedge clock);
    cpud_ack = 1'b1; cpud_rdata = 32'h55667788;
    @(negedge clock);
    cpud_ack = 1'b0;
    check("b2b_wb2", 32'(wb_valid), 32'd1);
    check("b2b_dest2", 32'(wb_dest), 32'd9);
    check("b2b_data2", wb_data, 32'h55667788);

    // reset while waiting
    @(negedge clock);
    in_valid = 1'b1; in_op = 3'd4; in_addr = 32'h600; in_dest = 5'd12;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({cpud_request, wb_valid, exc_valid}), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    cpud_ack = 1'b1; cpud_rdata = 32'hCAFEF00D;
    @(negedge clock);
    cpud_ack = 1'b0;
    check("late_ack_nowb", 32'({wb_valid, exc_valid}), 32'd0);
    check("late_ack_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 7));
      run_op(op, $urandom, $urandom, 5'($urandom), int'($urandom_range(1, TIMEOUT + 2)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_lsu.md
Name: cpu_lsu

Overview:
- Load/store unit between the CPU execute stage and the data-cache port (cpud_* bus).
- Accepts one memory op per handshake, checks alignment, and issues a single-cycle cpud_request with lane-replicated write data and byte enables.
- Waits for cpud_ack, then extracts and sign/zero-extends load data and returns it to writeback.
- Raises misalignment and bus-timeout exceptions; one outstanding request at most.

Parameters:
- TIMEOUT, 15, max cycles in WAIT without cpud_ack before a timeout exception (range 1..255).

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  execute stage presents an op
- in_ready  out  1  unit can accept an op this cycle
- in_op  in  3  lsu_op_t operation
- in_addr  in  32  effective byte address
- in_wdata  in  32  store data (low bits significant)
- in_dest  in  5  load destination register
- cpud_request  out  1  one-cycle request pulse to the data cache
- cpud_addr  out  32  request address
- cpud_write  out  1  1 = store
- cpud_byte_enable  out  4  store lane enables
- cpud_wdata  out  32  lane-replicated store data
- cpud_rdata  in  32  read data, valid only while cpud_ack = 1
- cpud_ack  in  1  cache response, one or more cycles after request
- wb_valid  out  1  one-cycle pulse: load result valid
- wb_dest  out  5  load destination
- wb_data  out  32  extended load data
- exc_valid  out  1  one-cycle exception pulse
- exc_cause  out  2  1 load misaligned, 2 store misaligned, 3 bus timeout
- exc_addr  out  32  faulting address

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = IDLE; all outputs 0 except in_ready = 1.
  - Timeout counter cleared; any in-flight op is abandoned.
  - A late cpud_ack after reset is ignored.
- Accept: in_valid && in_ready. Op, addr, wdata and dest are registered.
- in_ready = (state == IDLE) || (state == WAIT && cpud_ack).
  - This allows back-to-back issue: a new op may be accepted in the ack cycle.
- Alignment:
  - Halfword ops need addr[0] = 0; word ops need addr[1:0] = 0.
  - A misaligned op issues no request. Next cycle: exc_valid = 1, cause 1 (loads) or 2 (stores), exc_addr = addr. State stays IDLE.
- State machine:
  - IDLE -> REQ on an aligned accept.
  - REQ: cpud_request = 1 for exactly one cycle; cpud_* driven from registers. REQ -> WAIT.
  - WAIT: counter increments each cycle without cpud_ack.
    - On cpud_ack: the op completes; WAIT -> REQ if a new aligned op is accepted that cycle, else -> IDLE.
    - When the counter reaches TIMEOUT: exc_valid = 1, cause 3, exc_addr = op address; -> IDLE. An ack in that same cycle wins (no exception).
- cpud_ack in IDLE or REQ is spurious and ignored.
- Store encoding (cpud_write = 1):
  - SB: byte_enable = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: byte_enable = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: byte_enable = 4'b1111; wdata = wdata.
- Loads: cpud_write = 0, byte_enable = 4'b0000, cpud_wdata = 0.
- cpud_addr is the full byte address for every op.
- Load completion:
  - cpud_rdata is sampled only in the ack cycle and shifted right by 8*addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - wb_valid/wb_dest/wb_data are registered: valid one cycle after ack.
- Stores complete on ack with no wb_valid.
- Latency: accept at N -> request N+1 -> ack N+2 at the earliest -> wb_valid N+3.
- Invalid in_op encodings are treated as LW.

Decomposition:
- cpu_lsu_pkg holds:
  - lsu_op_t enum: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
  - lsu_state_t enum: IDLE, REQ, WAIT.
  - exc_cause constants.
- One sub-module, cpu_lsu_align: purely combinational store lane/byte-enable generation and load extract/extend, shared by both paths and unit-testable.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, ack after 1 cycle -> single request pulse, be = 1111, wdata 0xDEADBEEF, no wb_valid.
- SB addr 0x103 data 0x000000A5 -> be = 1000, wdata 0xA5A5A5A5. Then LB addr 0x103 with rdata 0xA5000000 -> wb_data 0xFFFFFFA5. LBU -> 0x000000A5.
- LH addr 0x102 with rdata 0x80010000 -> wb_data 0xFFFF8001. LW addr 0x102 -> no request, exc_valid next cycle, cause 1, exc_addr 0x102.
- Load with no ack, TIMEOUT = 15 -> exc cause 3 after 15 WAIT cycles, in_ready back to 1, no wb_valid. A later spurious ack is ignored.
- Back-to-back: LW issued in the ack cycle of the previous LW -> second request one cycle after the first ack; two wb_valid pulses with correct dests.
- reset_n asserted while in WAIT -> outputs clear immediately; ack after release produces no wb_valid.
